count_seq_monitor: RTL

- Consumer stage placed directly downstream of the 3-bit up/down counter.
- Samples the counter's count and mode every clock and classifies each step as up, down, hold or illegal.
- Reports wrap events (overflow 7->0, underflow 0->7) and keeps a saturating wrap tally.
- Flags sequence faults for the self-checking benches and the display stage.

---
 rtl/count_seq_pkg.sv | 20 ++
 rtl/count_step_classify.sv | 27 ++
 rtl/count_seq_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the counter sequence monitor and related counter checkers.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/count_step_classify.sv
// Combinational step classifier: compares a previous and current count modulo 2^WIDTH.
module count_step_classify
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] count_i,
    output step_e            step_o
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta = count_i - prev_i;
        if (delta == '0) begin
            step_o = STEP_HOLD;
        end else if (delta == WIDTH'(1)) begin
            step_o = STEP_UP;
        end else if (delta == '1) begin
            step_o = STEP_DOWN;
        end else begin
            step_o = STEP_ILLEGAL;
        end
    end

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors an up/down counter: classifies steps, flags wraps and sequence faults.
// Optional wrap-period measurement is enabled by defining COUNT_SEQ_MONITOR_PERIOD_EN.
module count_seq_monitor
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    input  logic             clr,
    output logic             ovf,
    output logic             unf,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             dir_err,
    output logic             step_err,
    output logic             tracking
`ifdef COUNT_SEQ_MONITOR_PERIOD_EN
    ,
    output logic [CNT_W-1:0] last_period
`endif
);

    localparam logic [WIDTH-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] TallyMax = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             dir_err_q, dir_err_d;
    logic             step_err_q, step_err_d;
    step_e            step;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev_i  (prev_q),
        .count_i (count),
        .step_o  (step)
    );

    always_comb begin
        state_d    = state_q;
        prev_d     = count;
        mode_d     = mode;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        wrap_d     = wrap_q;
        dir_err_d  = dir_err_q;
        step_err_d = step_err_q;

        if (clr) begin
            state_d    = IDLE;
            wrap_d     = '0;
            dir_err_d  = 1'b0;
            step_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = TRACK;
                TRACK: begin
                    // mode_q is the mode that produced the step now visible on count.
                    unique case (step)
                        STEP_UP: begin
                            ovf_d = (prev_q == CntMax);
                            if (mode_q == MODE_DOWN) dir_err_d = 1'b1;
                        end
                        STEP_DOWN: begin
                            unf_d = (prev_q == '0);
                            if (mode_q == MODE_UP) dir_err_d = 1'b1;
                        end
                        STEP_ILLEGAL: begin
                            step_err_d = 1'b1;
                            state_d    = FAULT;
                        end
                        default: ;
                    endcase
                end
                FAULT: ;
                default: state_d = IDLE;
            endcase

            if ((ovf_d || unf_d) && (wrap_q != TallyMax)) begin
                wrap_d = wrap_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wrap_q     <= '0;
            dir_err_q  <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wrap_q     <= wrap_d;
            dir_err_q  <= dir_err_d;
            step_err_q <= step_err_d;
        end
    end

    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign wrap_cnt = wrap_q;
    assign dir_err  = dir_err_q;
    assign step_err = step_err_q;
    assign tracking = (state_q == TRACK);

`ifdef COUNT_SEQ_MONITOR_PERIOD_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] period_q, period_d;

    // Period is the number of edges between consecutive overflow events.
    always_comb begin
        cyc_d    = cyc_q;
        period_d = period_q;
        if (clr) begin
            cyc_d    = '0;
            period_d = '0;
        end else if (ovf_d) begin
            period_d = (cyc_q == TallyMax) ? TallyMax : cyc_q + CNT_W'(1);
            cyc_d    = '0;
        end else if (cyc_q != TallyMax) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q    <= '0;
            period_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            period_q <= period_d;
        end
    end

    assign last_period = period_q;
`endif

endmodule
